// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts two operands over valid/ready, adds them
// LSB-first through one full adder cell, and holds the result until it is taken.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             cin,
   input  logic             clear,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT            state;
   stateT            stateNext;
   logic [CNT_W-1:0] bitCnt;
   logic [WIDTH-1:0] aReg;
   logic [WIDTH-1:0] bReg;
   logic [WIDTH-1:0] aNext;
   logic             carry;
   logic             accept;
   logic             step;
   logic             finish;
   logic             halfSum;
   logic             halfCarry0;
   logic             halfCarry1;
   logic             sumBit;
   logic             faCarry;

   // Full adder cell: two half adders plus an OR for the carry.
   halfAdder u_ha0 (.a(aReg[0]), .b(bReg[0]), .s(halfSum), .c(halfCarry0));
   halfAdder u_ha1 (.a(halfSum), .b(carry),   .s(sumBit),  .c(halfCarry1));
   assign faCarry = halfCarry0 | halfCarry1;

   // Sum bits enter the A register from the top as its operand bits drain out the bottom.
   if (WIDTH == 1) begin : gNarrow
      assign aNext = sumBit;
   end else begin : gWide
      assign aNext = {sumBit, aReg[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      accept    = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      if (clear) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (inValid) begin
                  accept    = 1'b1;
                  stateNext = RUN;
               end
            end
            RUN: begin
               step = 1'b1;
               if (bitCnt == CNT_W'(WIDTH - 1)) begin
                  finish    = 1'b1;
                  stateNext = DONE;
               end
            end
            DONE: begin
               if (outReady) begin
                  stateNext = IDLE;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // Datapath; completed results only move to sum/cout/ovf on the final bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitCnt <= '0;
         aReg   <= '0;
         bReg   <= '0;
         carry  <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else if (clear) begin
         bitCnt <= '0;
         carry  <= 1'b0;
      end else if (accept) begin
         aReg   <= opA;
         bReg   <= opB;
         carry  <= cin;
         bitCnt <= '0;
      end else if (step) begin
         aReg   <= aNext;
         bReg   <= bReg >> 1;
         carry  <= faCarry;
         bitCnt <= bitCnt + CNT_W'(1);
         if (finish) begin
            sum  <= aNext;
            cout <= faCarry;
            ovf  <= faCarry ^ carry;
         end
      end
   end

   assign inReady  = (state == IDLE);
   assign outValid = (state == DONE);
   assign busy     = (state == RUN);

endmodule

// Half adder cell used to build the serial full adder.
module halfAdder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: arithmetic/timing model checked every cycle on an
// 8-bit instance, plus directed literal checks and a 1-bit truth-table sweep.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       inValid, inReady, cin, clear, outValid, outReady, cout, ovf, busy;
   logic [7:0] opA, opB, sum;

   logic       inValid1, inReady1, cin1, outValid1, outReady1, cout1, ovf1, busy1, clear1;
   logic [0:0] opA1, opB1, sum1;

   int nChecks = 0;
   int nErrors = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
      .opA(opA), .opB(opB), .cin(cin), .clear(clear), .outValid(outValid),
      .outReady(outReady), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .inValid(inValid1), .inReady(inReady1),
      .opA(opA1), .opB(opB1), .cin(cin1), .clear(clear1), .outValid(outValid1),
      .outReady(outReady1), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result {ovf, cout, sum[7:0]} from plain arithmetic and sign rules.
   function automatic logic [9:0] addRef(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] full;
      logic       o;
      full = 9'(a) + 9'(b) + 9'(c);
      o    = (a[7] == b[7]) && (full[7] != a[7]);
      return {o, full};
   endfunction

   // Transaction-level model: cycles left in flight, result-held flag, last completed result.
   int         mRem;
   logic       mHold;
   logic [7:0] mSum;
   logic       mCout, mOvf;
   logic [9:0] pRes;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mRem <= 0; mHold <= 1'b0; mSum <= '0; mCout <= 1'b0; mOvf <= 1'b0; pRes <= '0;
      end else if (clear) begin
         mRem <= 0; mHold <= 1'b0;
      end else if (mHold) begin
         if (outReady) mHold <= 1'b0;
      end else if (mRem != 0) begin
         mRem <= mRem - 1;
         if (mRem == 1) begin
            mHold <= 1'b1;
            {mOvf, mCout, mSum} <= pRes;
         end
      end else if (inValid) begin
         mRem <= 8;
         pRes <= addRef(opA, opB, cin);
      end
   end

   always @(negedge clk) begin
      check("cmp inReady",  32'(inReady),  32'(!mHold && mRem == 0));
      check("cmp busy",     32'(busy),     32'(mRem != 0));
      check("cmp outValid", 32'(outValid), 32'(mHold));
      check("cmp sum",      32'(sum),      32'(mSum));
      check("cmp cout",     32'(cout),     32'(mCout));
      check("cmp ovf",      32'(ovf),      32'(mOvf));
   end

   // One add on the 8-bit DUT: latency, literal result, optional hold with stray inValid, release.
   task automatic doAdd(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] eS, input logic eC, input logic eO, input int holdCyc);
      int lat;
      opA = a; opB = b; cin = c; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      lat = 0;
      while (!outValid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({nm, " latency"}, 32'(lat), 32'd8);
      check({nm, " sum"},  32'(sum),  32'(eS));
      check({nm, " cout"}, 32'(cout), 32'(eC));
      check({nm, " ovf"},  32'(ovf),  32'(eO));
      for (int i = 0; i < holdCyc; i++) begin
         inValid = 1'b1; opA = ~a; opB = ~b;
         @(posedge clk); #1;
         check({nm, " hold outValid"}, 32'(outValid), 32'd1);
         check({nm, " hold inReady"},  32'(inReady),  32'd0);
         check({nm, " hold sum"},      32'(sum),      32'(eS));
      end
      inValid = 1'b0; outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      check({nm, " release inReady"},  32'(inReady),  32'd1);
      check({nm, " release outValid"}, 32'(outValid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; inValid = 1'b0; opA = '0; opB = '0; cin = 1'b0; clear = 1'b0; outReady = 1'b0;
      inValid1 = 1'b0; opA1 = '0; opB1 = '0; cin1 = 1'b0; clear1 = 1'b0; outReady1 = 1'b1;
      #12;
      check("reset inReady",  32'(inReady),  32'd1);
      check("reset outValid", 32'(outValid), 32'd0);
      check("reset busy",     32'(busy),     32'd0);
      check("reset sum",      32'(sum),      32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      doAdd("t1 0F+01",   8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
      doAdd("t2 FF+01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      doAdd("t2 7F+00+1", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0);

      // Abort at the third RUN cycle; previous result must survive.
      opA = 8'hAA; opB = 8'h55; cin = 1'b0; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("t4 clear inReady", 32'(inReady), 32'd1);
      check("t4 clear busy",    32'(busy),    32'd0);
      repeat (12) begin @(posedge clk); #1; end
      check("t4 no outValid",  32'(outValid), 32'd0);
      check("t4 kept sum",     32'(sum),      32'h80);
      check("t4 kept ovf",     32'(ovf),      32'd1);
      doAdd("t4 AA+55+1", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 0);

      doAdd("t3 80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 10);

      // Asynchronous reset in the middle of RUN.
      opA = 8'h12; opB = 8'h34; cin = 1'b0; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      check("t5 pre busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5 async inReady",  32'(inReady),  32'd1);
      check("t5 async busy",     32'(busy),     32'd0);
      check("t5 async outValid", 32'(outValid), 32'd0);
      check("t5 async cout",     32'(cout),     32'd0);
      check("t5 async ovf",      32'(ovf),      32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t5 after inReady", 32'(inReady), 32'd1);

      // WIDTH=1 truth-table sweep.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         logic       ea, eb, ec, es, eco, eov;
         v = 3'(i);
         ea = v[2]; eb = v[1]; ec = v[0];
         {eco, es} = 2'(ea) + 2'(eb) + 2'(ec);
         eov = (ea == eb) && (es != ea);
         opA1 = ea; opB1 = eb; cin1 = ec; inValid1 = 1'b1;
         @(posedge clk); #1;
         inValid1 = 1'b0;
         check("t6 w1 busy",        32'(busy1),     32'd1);
         check("t6 w1 early valid", 32'(outValid1), 32'd0);
         @(posedge clk); #1;
         check("t6 w1 outValid", 32'(outValid1), 32'd1);
         check("t6 w1 sum",      32'(sum1),      32'(es));
         check("t6 w1 cout",     32'(cout1),     32'(eco));
         check("t6 w1 ovf",      32'(ovf1),      32'(eov));
         @(posedge clk); #1;
         check("t6 w1 inReady", 32'(inReady1), 32'd1);
      end

      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
